// File: rtl/synchronizer_pkg.sv
// rtl/synchronizer_pkg.sv - shared limits and helpers for the multi-flop CDC synchronizer
package synchronizer_pkg;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 8;

  // Fewer than two flops gives no metastability settling time; more than eight is never needed.
  function automatic bit stages_legal(input int stages);
    return (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
  endfunction

endpackage

// File: rtl/synchronizer_if.sv
// rtl/synchronizer_if.sv - async level in, synchronized level and edge pulses out
interface synchronizer_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] async_sig_i;
  logic [WIDTH-1:0] sync_sig_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;

  modport master (
    output async_sig_i,
    input  sync_sig_o,
    input  rise_o,
    input  fall_o
  );

  modport slave (
    input  async_sig_i,
    output sync_sig_o,
    output rise_o,
    output fall_o
  );

endinterface

// File: rtl/synchronizer_sync_bit.sv
// rtl/synchronizer_sync_bit.sv - one-bit STAGES-deep synchronizing flop chain
module synchronizer_sync_bit
  import synchronizer_pkg::*;
#(
  parameter int   STAGES  = 3,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;

  // Every stage resets to the same value so no spurious edge leaves the chain on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/synchronizer.sv
// rtl/synchronizer.sv - WIDTH independent CDC chains plus rise/fall pulses on the synced level
module synchronizer
  import synchronizer_pkg::*;
#(
  parameter int   STAGES  = 3,
  parameter int   WIDTH   = 1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  synchronizer_if.slave  bus
);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] hist_q;

  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("synchronizer: STAGES=%0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
  end

  // Bits are not coherent with each other; buses need a handshake or FIFO instead.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    synchronizer_sync_bit #(
      .STAGES  (STAGES),
      .RST_VAL (RST_VAL)
    ) u_sync_bit (
      .clk (clk),
      .rst (rst),
      .d   (bus.async_sig_i[i]),
      .q   (sync_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= {WIDTH{RST_VAL}};
    end else begin
      hist_q <= sync_q;
    end
  end

  assign bus.sync_sig_o = sync_q;
  assign bus.rise_o     = sync_q & ~hist_q;
  assign bus.fall_o     = ~sync_q & hist_q;

endmodule

// File: tb/tb_synchronizer.sv
// tb/tb_synchronizer.sv - directed checks of latency, pulses, glitch rejection, reset and parameters
module tb_synchronizer;

  logic clk;
  logic rst;

  int n_tests;
  int n_fail;
  int n_rise;
  int n_fall;
  logic [0:11] pat;

  synchronizer_if #(.WIDTH(1)) if_main ();
  synchronizer_if #(.WIDTH(1)) if_s2 ();
  synchronizer_if #(.WIDTH(1)) if_s8 ();
  synchronizer_if #(.WIDTH(4)) if_w4 ();
  synchronizer_if #(.WIDTH(1)) if_rv1 ();

  synchronizer #(.STAGES(3), .WIDTH(1), .RST_VAL(1'b0)) dut_main (.clk(clk), .rst(rst), .bus(if_main));
  synchronizer #(.STAGES(2), .WIDTH(1), .RST_VAL(1'b0)) dut_s2   (.clk(clk), .rst(rst), .bus(if_s2));
  synchronizer #(.STAGES(8), .WIDTH(1), .RST_VAL(1'b0)) dut_s8   (.clk(clk), .rst(rst), .bus(if_s8));
  synchronizer #(.STAGES(3), .WIDTH(4), .RST_VAL(1'b0)) dut_w4   (.clk(clk), .rst(rst), .bus(if_w4));
  synchronizer #(.STAGES(3), .WIDTH(1), .RST_VAL(1'b1)) dut_rv1  (.clk(clk), .rst(rst), .bus(if_rv1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    pat     = 12'b0011_0011_1111;

    // Reset with inputs held at the opposite of the reset value
    rst = 1'b1;
    if_main.async_sig_i = 1'b1;
    if_s2.async_sig_i   = 1'b1;
    if_s8.async_sig_i   = 1'b1;
    if_w4.async_sig_i   = 4'b1111;
    if_rv1.async_sig_i  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("rst_sync",     if_main.sync_sig_o, 0);
      check("rst_rise",     if_main.rise_o, 0);
      check("rst_fall",     if_main.fall_o, 0);
      check("rst_w4_sync",  if_w4.sync_sig_o, 0);
      check("rst_rv1_sync", if_rv1.sync_sig_o, 1);
      check("rst_rv1_fall", if_rv1.fall_o, 0);
    end

    if_main.async_sig_i = 1'b0;
    if_s2.async_sig_i   = 1'b0;
    if_s8.async_sig_i   = 1'b0;
    if_w4.async_sig_i   = 4'b0000;
    tick(1);
    rst = 1'b0;

    // Release: zero inputs stay zero; RST_VAL=1 instance falls after 3 edges with one pulse
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      check("rel_sync",     if_main.sync_sig_o, 0);
      check("rel_rise",     if_main.rise_o, 0);
      check("rel_fall",     if_main.fall_o, 0);
      check("rel_rv1_sync", if_rv1.sync_sig_o, (k < 3) ? 1 : 0);
      check("rel_rv1_fall", if_rv1.fall_o, (k == 3) ? 1 : 0);
      check("rel_rv1_rise", if_rv1.rise_o, 0);
    end

    // Latency for STAGES=3, 2, 8 and the 4-bit pattern
    if_main.async_sig_i = 1'b1;
    if_s2.async_sig_i   = 1'b1;
    if_s8.async_sig_i   = 1'b1;
    if_w4.async_sig_i   = 4'b1010;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      check("lat3_sync", if_main.sync_sig_o, (k >= 3) ? 1 : 0);
      check("lat3_rise", if_main.rise_o, (k == 3) ? 1 : 0);
      check("lat2_sync", if_s2.sync_sig_o, (k >= 2) ? 1 : 0);
      check("lat2_rise", if_s2.rise_o, (k == 2) ? 1 : 0);
      check("lat8_sync", if_s8.sync_sig_o, (k >= 8) ? 1 : 0);
      check("lat8_rise", if_s8.rise_o, (k == 8) ? 1 : 0);
      check("w4_sync",   if_w4.sync_sig_o, (k >= 3) ? 32'hA : 32'h0);
      check("w4_rise",   if_w4.rise_o, (k == 3) ? 32'hA : 32'h0);
      check("w4_fall",   if_w4.fall_o, 0);
    end

    // Toggle train: two-cycle levels, output is the input delayed by two edges after capture
    n_rise = 0;
    n_fall = 0;
    for (int k = 0; k < 12; k++) begin
      if_main.async_sig_i = pat[k];
      tick(1);
      check("tog_sync", if_main.sync_sig_o, (k >= 2) ? {31'd0, pat[k-2]} : 1);
      check("tog_excl", if_main.rise_o & if_main.fall_o, 0);
      if (if_main.rise_o) n_rise++;
      if (if_main.fall_o) n_fall++;
    end
    check("tog_rises", n_rise, 2);
    check("tog_falls", n_fall, 2);

    // Sub-period glitch between edges must not reach the output
    if_main.async_sig_i = 1'b0;
    tick(4);
    check("pre_glitch", if_main.sync_sig_o, 0);
    #2 if_main.async_sig_i = 1'b1;
    #3 if_main.async_sig_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("glitch_sync", if_main.sync_sig_o, 0);
      check("glitch_rise", if_main.rise_o, 0);
      check("glitch_fall", if_main.fall_o, 0);
    end

    // Reset one edge after the input rises discards the in-flight value
    if_main.async_sig_i = 1'b1;
    tick(1);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("mid_rst_sync", if_main.sync_sig_o, 0);
      check("mid_rst_rise", if_main.rise_o, 0);
    end
    rst = 1'b0;
    n_rise = 0;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      check("mid_rel_sync", if_main.sync_sig_o, (k >= 3) ? 1 : 0);
      if (if_main.rise_o) n_rise++;
    end
    check("mid_rel_rises", n_rise, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
